// File: rtl/rle_pkg.sv
// Shared RLE codec definitions: mode encodings, group-mask constants, FSM states
// and the decoded-word layout used by both rle_enc and rle_dec.
package rle_pkg;

  typedef enum logic [1:0] {
    MODE_8  = 2'd0,
    MODE_16 = 2'd1,
    MODE_32 = 2'd2
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    REPEAT = 1'b1
  } state_e;

  localparam logic [3:0] MASK_8  = 4'b1110;
  localparam logic [3:0] MASK_16 = 4'b1100;

  // Flag plus zero-extended field of one encoded word.
  typedef struct packed {
    logic        flag;
    logic [30:0] field;
  } word_t;

  function automatic mode_e mode_from_mask(input logic [3:0] mask);
    case (mask)
      MASK_8:  return MODE_8;
      MASK_16: return MODE_16;
      default: return MODE_32;
    endcase
  endfunction

endpackage

// File: rtl/rle_field_sel.sv
// Splits an encoded word into run flag and zero-extended field for the given mode.
// Purely combinational, no handshake.
module rle_field_sel
  import rle_pkg::*;
(
  input  mode_e       mode_i,
  input  logic [31:0] data_i,
  output word_t       word_o
);

  always_comb begin
    word_o = '0;
    case (mode_i)
      MODE_8: begin
        word_o.flag  = data_i[7];
        word_o.field = {24'd0, data_i[6:0]};
      end
      MODE_16: begin
        word_o.flag  = data_i[15];
        word_o.field = {16'd0, data_i[14:0]};
      end
      default: begin
        word_o.flag  = data_i[31];
        word_o.field = data_i[30:0];
      end
    endcase
  end

endmodule

// File: rtl/rle_dec.sv
// RLE decoder: value words emit one sample, count words repeat the last value N times;
// 1-cycle latency, one sample per cycle, readyOut held low while a run is expanding.
module rle_dec
  import rle_pkg::*;
#(
  parameter int CNT_W = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  disabledGroups,
  input  logic [31:0] dataIn,
  input  logic        validIn,
  output logic        readyOut,
  output logic [31:0] dataOut,
  output logic        validOut,
  input  logic        readyIn,
  output logic        error
);

  state_e           state_q;
  mode_e            mode_q;
  mode_e            mode_d;
  logic             enable_q;
  logic             init_q;
  logic [CNT_W-1:0] counter_q;
  logic [CNT_W-1:0] count_d;
  logic [30:0]      last_value_q;
  logic             have_value_q;
  logic [31:0]      data_q;
  logic             valid_q;
  logic             error_q;
  word_t            word;
  logic             out_free;
  logic             in_xfer;

  // The mask is sampled only on the enable rising edge; that same cycle already decodes with it.
  assign mode_d = (enable && !enable_q) ? mode_from_mask(disabledGroups) : mode_q;

  rle_field_sel u_field_sel (
    .mode_i (mode_d),
    .data_i (dataIn),
    .word_o (word)
  );

  assign count_d  = word.field[CNT_W-1:0];
  assign out_free = !valid_q || readyIn;
  // init_q keeps readyOut low until the first edge after reset is released.
  assign readyOut = init_q && (state_q == IDLE) && out_free;
  assign in_xfer  = validIn && readyOut;

  assign dataOut  = data_q;
  assign validOut = valid_q;
  assign error    = error_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= MODE_32;
      enable_q     <= 1'b0;
      init_q       <= 1'b0;
      counter_q    <= '0;
      last_value_q <= '0;
      have_value_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      init_q   <= 1'b1;
      enable_q <= enable;
      mode_q   <= mode_d;
      if (out_free) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (!enable) begin
            if (readyOut) begin
              data_q  <= dataIn;
              valid_q <= validIn;
            end
          end else if (in_xfer) begin
            if (!word.flag) begin
              last_value_q <= word.field;
              have_value_q <= 1'b1;
              data_q       <= {1'b0, word.field};
              valid_q      <= 1'b1;
            end else if (!have_value_q) begin
              error_q <= 1'b1;
            end else if (count_d != '0) begin
              counter_q <= count_d;
              state_q   <= REPEAT;
            end
          end
        end
        REPEAT: begin
          // Runs to completion even if enable drops; pass-through resumes in IDLE.
          if (out_free) begin
            data_q    <= {1'b0, last_value_q};
            valid_q   <= 1'b1;
            counter_q <= counter_q - CNT_W'(1);
            if (counter_q == CNT_W'(1)) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_dec.sv
// Randomized and directed bench for rle_dec against a queue-based expansion model.
module tb_rle_dec;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  disabledGroups = 4'b0000;
  logic [31:0] dataIn = '0;
  logic        validIn = 1'b0;
  logic        readyIn = 1'b0;
  logic        readyOut;
  logic [31:0] dataOut;
  logic        validOut;
  logic        error;

  rle_dec #(.CNT_W(31)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .disabledGroups (disabledGroups),
    .dataIn         (dataIn),
    .validIn        (validIn),
    .readyOut       (readyOut),
    .dataOut        (dataOut),
    .validOut       (validOut),
    .readyIn        (readyIn),
    .error          (error)
  );

  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  bit          m_have, m_err, en_prev, acc, stalled;
  logic [31:0] m_last, held, last_out;
  int          m_fp = 31;
  int          out_cnt = 0;
  int          ro_low = 0;
  int          stall_cnt = 0;
  int          rdy_mode = 0;
  int          cur_fp = 31;

  function automatic int fp_of(input logic [3:0] m);
    if (m == 4'b1110) return 7;
    if (m == 4'b1100) return 15;
    return 31;
  endfunction

  function automatic logic [31:0] low_mask(input int fp);
    return (32'h1 << fp) - 32'h1;
  endfunction

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    fails++;
    $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: every accepted word turns into its list of output samples.
  task automatic model_accept(input logic [31:0] w);
    logic [31:0] f;
    if (!enable) begin
      exp_q.push_back(w);
      return;
    end
    f = w & low_mask(m_fp);
    if (!w[m_fp[4:0]]) begin
      m_have = 1'b1;
      m_last = f;
      exp_q.push_back(f);
    end else if (!m_have) begin
      m_err = 1'b1;
    end else begin
      for (int i = 0; i < int'(f); i++) exp_q.push_back(m_last);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_have  = 1'b0;
      m_last  = '0;
      m_err   = 1'b0;
      m_fp    = 31;
      en_prev = 1'b0;
      stalled = 1'b0;
      acc     = 1'b0;
    end else begin
      if (stalled) begin
        chk_eq("hold_valid", 32'(validOut), 32'd1);
        chk_eq("hold_data", dataOut, held);
      end
      if (validOut && readyIn) begin
        out_cnt++;
        last_out = dataOut;
        if (exp_q.size() == 0) report_fail("extra_out", dataOut, 32'd0);
        else chk_eq("out_data", dataOut, exp_q.pop_front());
      end
      stalled = validOut && !readyIn;
      if (stalled) stall_cnt++;
      held = dataOut;
      chk_eq("error", 32'(error), 32'(m_err));
      if (!readyOut) ro_low++;
      acc = validIn && readyOut;
      if (enable && !en_prev) m_fp = fp_of(disabledGroups);
      en_prev = enable;
      if (acc) model_accept(dataIn);
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        1:       readyIn = 1'($urandom_range(0, 1));
        2:       readyIn = ~readyIn;
        default: readyIn = 1'b1;
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    bit ok;
    n = 0;
    dataIn  = w;
    validIn = 1'b1;
    do begin
      @(posedge clock);
      n++;
    end while (!acc && n < 400);
    ok = acc;
    #1;
    validIn = 1'b0;
    if (!ok) report_fail("send_timeout", w, 32'd0);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || validOut) && n < limit) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (exp_q.size() != 0 || validOut) report_fail("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk_eq("rst_valid", 32'(validOut), 32'd0);
    chk_eq("rst_ready", 32'(readyOut), 32'd0);
    chk_eq("rst_data", dataOut, 32'd0);
    chk_eq("rst_error", 32'(error), 32'd0);
    idle(2);
    reset = 1'b0;
    #1;
    chk_eq("ready_before_edge", 32'(readyOut), 32'd0);
    @(posedge clock);
    #1;
    chk_eq("ready_after_edge", 32'(readyOut), 32'd1);
  endtask

  function automatic logic [31:0] gen_word(input int fp, input logic en);
    logic [31:0] w;
    w = $urandom;
    if (en) begin
      if ($urandom_range(0, 2) == 0) begin
        w = (w & ~low_mask(fp)) | 32'($urandom_range(0, 5));
        w[fp[4:0]] = 1'b1;
      end else begin
        w[fp[4:0]] = 1'b0;
      end
    end
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base_low, base_stall, n;
    #2;
    do_reset();

    // pass-through
    send(32'h41414141);
    chk_eq("pt_valid", 32'(validOut), 32'd1);
    chk_eq("pt_data", dataOut, 32'h41414141);
    drain(20);

    // 8-bit mode: one value plus three repeats
    disabledGroups = 4'b1110;
    enable = 1'b1;
    cur_fp = 7;
    base = out_cnt;
    base_low = ro_low;
    send(32'h44);
    send(32'h83);
    drain(50);
    chk_eq("m8_count", 32'(out_cnt - base), 32'd4);
    chk_eq("m8_rdy_low", 32'(ro_low - base_low), 32'd3);
    chk_eq("m8_last", last_out, 32'h44);

    // 32-bit mode: 1 + 128 samples
    enable = 1'b0;
    idle(2);
    disabledGroups = 4'b0000;
    enable = 1'b1;
    cur_fp = 31;
    base = out_cnt;
    send(32'h4C4C4C4C);
    send(32'h80000080);
    drain(400);
    chk_eq("m32_count", 32'(out_cnt - base), 32'd129);
    chk_eq("m32_last", last_out, 32'h4C4C4C4C);
    chk_eq("m32_idle_ready", 32'(readyOut), 32'd1);

    // backpressure with readyIn toggling
    enable = 1'b0;
    idle(2);
    disabledGroups = 4'b1110;
    enable = 1'b1;
    cur_fp = 7;
    base = out_cnt;
    base_stall = stall_cnt;
    rdy_mode = 2;
    send(32'h21);
    send(32'h84);
    drain(100);
    rdy_mode = 0;
    idle(1);
    chk_eq("bp_count", 32'(out_cnt - base), 32'd5);
    chk_eq("bp_last", last_out, 32'h21);
    chk_eq("bp_stalled", 32'(stall_cnt > base_stall), 32'd1);

    // count word with no preceding value
    enable = 1'b0;
    do_reset();
    disabledGroups = 4'b1110;
    enable = 1'b1;
    cur_fp = 7;
    base = out_cnt;
    send(32'h85);
    idle(3);
    chk_eq("err_flag", 32'(error), 32'd1);
    chk_eq("err_no_out", 32'(out_cnt - base), 32'd0);
    send(32'h12);
    drain(20);
    chk_eq("err_then_value", 32'(out_cnt - base), 32'd1);
    chk_eq("err_value_data", last_out, 32'h12);
    chk_eq("err_sticky", 32'(error), 32'd1);

    // reset in the middle of a 100-sample run
    enable = 1'b0;
    idle(2);
    disabledGroups = 4'b0000;
    enable = 1'b1;
    cur_fp = 31;
    base = out_cnt;
    send(32'h55);
    send(32'h80000064);
    n = 0;
    while (out_cnt - base < 10 && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk_eq("rr_reached", 32'(out_cnt - base), 32'd10);
    reset = 1'b1;
    #1;
    chk_eq("rr_valid", 32'(validOut), 32'd0);
    chk_eq("rr_error", 32'(error), 32'd0);
    idle(2);
    reset = 1'b0;
    enable = 1'b0;
    idle(20);
    chk_eq("rr_no_more", 32'(out_cnt - base), 32'd10);
    chk_eq("rr_idle_valid", 32'(validOut), 32'd0);

    // randomized traffic with mode changes and random backpressure
    rdy_mode = 1;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        if (enable) begin
          enable = 1'b0;
        end else begin
          case ($urandom_range(0, 2))
            0:       disabledGroups = 4'b1110;
            1:       disabledGroups = 4'b1100;
            default: disabledGroups = 4'($urandom_range(0, 15));
          endcase
          cur_fp = fp_of(disabledGroups);
          enable = 1'b1;
        end
      end else if (enable && $urandom_range(0, 29) == 0) begin
        disabledGroups = 4'($urandom);
      end
      send(gen_word(cur_fp, enable));
      idle($urandom_range(0, 1));
    end
    rdy_mode = 0;
    drain(2000);
    chk_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
